// File: rtl/fmap_sram_ahb_slave_if.sv
// rtl/fmap_sram_ahb_slave_if.sv - AHB-Lite single-slave bus bundle for the feature-map SRAM
interface fmap_sram_ahb_slave_if;
  logic        sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready_in;
  logic [31:0] hrdata;
  logic        hready_out;
  logic        hresp;

  modport master (
    output sel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_in,
    input  hrdata, hready_out, hresp
  );

  modport slave (
    input  sel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready_in,
    output hrdata, hready_out, hresp
  );
endinterface

// File: rtl/fmap_sram_ahb_slave.sv
// rtl/fmap_sram_ahb_slave.sv - AHB-Lite responder over the CNN feature-map byte SRAM
// Zero-wait reads, one-wait writes, two-cycle ERROR; side-band byte load port.
module fmap_sram_ahb_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h4002_0000,
  parameter int          ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  fmap_sram_ahb_slave_if.slave  AHB_INTERFACE_0,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [7:0]            load_data,
  output logic                  busy
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, RD, WR_WAIT, WR_DONE, ERR1, ERR2} state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [2:0]            wr_bytes;
  logic                  accept;
  logic                  legal;
  logic [2:0]            size_bytes;
  logic [31:0]           rd_word;
  logic                  unused_ok;

  assign unused_ok = ^{AHB_INTERFACE_0.hburst, AHB_INTERFACE_0.hprot, AHB_INTERFACE_0.htrans[0]};

  assign accept = AHB_INTERFACE_0.sel && AHB_INTERFACE_0.htrans[1] &&
                  AHB_INTERFACE_0.hready_in && AHB_INTERFACE_0.hready_out;

  always_comb begin
    legal = (AHB_INTERFACE_0.haddr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]) &&
            ((AHB_INTERFACE_0.hsize == 3'b000) ||
             (AHB_INTERFACE_0.hsize == 3'b001 && !AHB_INTERFACE_0.haddr[0]) ||
             (AHB_INTERFACE_0.hsize == 3'b010 && AHB_INTERFACE_0.haddr[1:0] == 2'b00));
    case (AHB_INTERFACE_0.hsize)
      3'b000:  size_bytes = 3'd1;
      3'b001:  size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  end

  // Bytes beyond the transfer size stay zero so narrow reads come out zero-extended.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(size_bytes))
        rd_word[8*i +: 8] = mem[AHB_INTERFACE_0.haddr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i)];
    end
  end

  // Backdoor first, AHB commit second: on a same-byte collision the bus data lands last.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (load_en)
        mem[load_addr] <= load_data;
      if (state == WR_WAIT) begin
        for (int i = 0; i < 4; i++) begin
          if (i < int'(wr_bytes))
            mem[wr_addr + ADDR_WIDTH'(i)] <= AHB_INTERFACE_0.hwdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state                      <= IDLE;
      AHB_INTERFACE_0.hready_out <= 1'b1;
      AHB_INTERFACE_0.hresp      <= 1'b0;
      AHB_INTERFACE_0.hrdata     <= '0;
      busy                       <= 1'b0;
    end else begin
      case (state)
        WR_WAIT: begin
          state                      <= WR_DONE;
          AHB_INTERFACE_0.hready_out <= 1'b1;
          AHB_INTERFACE_0.hresp      <= 1'b0;
          busy                       <= 1'b1;
        end
        ERR1: begin
          state                      <= ERR2;
          AHB_INTERFACE_0.hready_out <= 1'b1;
          AHB_INTERFACE_0.hresp      <= 1'b1;
          busy                       <= 1'b1;
        end
        default: begin
          if (accept && !legal) begin
            state                      <= ERR1;
            AHB_INTERFACE_0.hready_out <= 1'b0;
            AHB_INTERFACE_0.hresp      <= 1'b1;
            busy                       <= 1'b1;
          end else if (accept && AHB_INTERFACE_0.hwrite) begin
            state                      <= WR_WAIT;
            AHB_INTERFACE_0.hready_out <= 1'b0;
            AHB_INTERFACE_0.hresp      <= 1'b0;
            busy                       <= 1'b1;
            wr_addr                    <= AHB_INTERFACE_0.haddr[ADDR_WIDTH-1:0];
            wr_bytes                   <= size_bytes;
          end else if (accept) begin
            state                      <= RD;
            AHB_INTERFACE_0.hready_out <= 1'b1;
            AHB_INTERFACE_0.hresp      <= 1'b0;
            AHB_INTERFACE_0.hrdata     <= rd_word;
            busy                       <= 1'b1;
          end else begin
            state                      <= IDLE;
            AHB_INTERFACE_0.hready_out <= 1'b1;
            AHB_INTERFACE_0.hresp      <= 1'b0;
            busy                       <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fmap_sram_ahb_slave.sv
// tb/tb_fmap_sram_ahb_slave.sv - self-checking bench for fmap_sram_ahb_slave
module tb_fmap_sram_ahb_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        load_en;
  logic [13:0] load_addr;
  logic [7:0]  load_data;
  logic        busy;

  fmap_sram_ahb_slave_if ahb();

  fmap_sram_ahb_slave dut (
    .clk            (clk),
    .reset          (reset),
    .AHB_INTERFACE_0(ahb),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .busy           (busy)
  );

  typedef struct {
    bit          rdy;
    bit          resp;
    bit          bsy;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  logic [7:0]  mem_m [16384];
  logic [31:0] last_rd;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("hready_out", {31'b0, ahb.hready_out}, {31'b0, cur.rdy});
      chk("hresp", {31'b0, ahb.hresp}, {31'b0, cur.resp});
      chk("busy", {31'b0, busy}, {31'b0, cur.bsy});
      chk("hrdata", ahb.hrdata, cur.data);
    end
  end

  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
    return ((a & 32'hFFFF_C000) == 32'h4002_0000) &&
           (sz == 3'd0 || (sz == 3'd1 && a[0] == 1'b0) || (sz == 3'd2 && a[1:0] == 2'b00));
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] v = '0;
    for (int i = 0; i < (1 << sz); i++) v[8*i +: 8] = mem_m[14'(a + 32'(i))];
    return v;
  endfunction

  // Each step states what the outputs must be in the cycle after the coming edge.
  task automatic step(input bit rdy, input bit resp, input bit bsy);
    exp_t e;
    e.rdy = rdy; e.resp = resp; e.bsy = bsy; e.data = last_rd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ahb.sel = 1'b0; ahb.htrans = 2'b00; ahb.hwrite = 1'b0; load_en = 1'b0;
  endtask

  task automatic idle();
    drive_idle();
    step(1'b1, 1'b0, 1'b0);
  endtask

  task automatic addr_phase(input logic [31:0] a, input bit w, input logic [2:0] sz);
    ahb.sel = 1'b1; ahb.htrans = 2'b10; ahb.haddr = a; ahb.hwrite = w; ahb.hsize = sz;
    load_en = 1'b0;
  endtask

  task automatic load(input logic [13:0] la, input logic [7:0] d);
    drive_idle();
    load_en = 1'b1; load_addr = la; load_data = d;
    step(1'b1, 1'b0, 1'b0);
    mem_m[la] = d;
    load_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [2:0] sz);
    addr_phase(a, 1'b0, sz);
    if (legal(a, sz)) begin
      last_rd = model_rd(a, sz);
      step(1'b1, 1'b0, 1'b1);
    end else begin
      step(1'b0, 1'b1, 1'b1);
      drive_idle();
      step(1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                    input bit ld, input logic [13:0] la, input logic [7:0] ldat);
    addr_phase(a, 1'b1, sz);
    if (legal(a, sz)) begin
      step(1'b0, 1'b0, 1'b1);
      drive_idle();
      ahb.hwdata = d; load_en = ld; load_addr = la; load_data = ldat;
      step(1'b1, 1'b0, 1'b1);
      if (ld) mem_m[la] = ldat;
      for (int i = 0; i < (1 << sz); i++) mem_m[14'(a + 32'(i))] = d[8*i +: 8];
      load_en = 1'b0;
    end else begin
      step(1'b0, 1'b1, 1'b1);
      drive_idle();
      ahb.hwdata = d;
      step(1'b1, 1'b1, 1'b1);
    end
  endtask

  initial begin
    reset = 1'b0;
    drive_idle();
    ahb.haddr = '0; ahb.hsize = 3'd0; ahb.hburst = 3'd0; ahb.hprot = 4'd0;
    ahb.hwdata = '0; ahb.hready_in = 1'b1;
    load_addr = '0; load_data = '0;
    last_rd = '0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    idle();

    for (int i = 0; i < 32; i++) load(14'(i), 8'(8'h30 + i));
    load(14'h52, 8'h11);
    load(14'h53, 8'h22);

    chk("model_hw52", model_rd(32'h4002_0052, 3'd1), 32'h0000_2211);
    rd(32'h4002_0052, 3'd1);
    idle();

    wr(32'h4002_0003, 3'd0, 32'hFFFF_FFAB, 1'b0, 14'h0, 8'h0);
    rd(32'h4002_0003, 3'd0);
    chk("model_b3", last_rd, 32'h0000_00AB);
    rd(32'h4002_0002, 3'd0);
    chk("model_b2", last_rd, 32'h0000_0032);
    rd(32'h4002_0004, 3'd0);
    chk("model_b4", last_rd, 32'h0000_0034);
    idle();

    rd(32'h4002_0001, 3'd1);
    rd(32'h4002_0000, 3'd2);
    chk("model_w0", last_rd, 32'hAB32_3130);
    rd(32'h4002_0002, 3'd2);
    rd(32'h4002_0000, 3'd3);
    idle();

    wr(32'h4002_4000, 3'd2, 32'hDEAD_BEEF, 1'b0, 14'h0, 8'h0);
    rd(32'h4002_0000, 3'd0);
    chk("model_b0", last_rd, 32'h0000_0030);
    idle();

    rd(32'h4002_0000, 3'd1);
    rd(32'h4002_0002, 3'd1);
    rd(32'h4002_0004, 3'd1);
    rd(32'h4002_0006, 3'd1);
    chk("model_hw6", last_rd, 32'h0000_3736);
    idle();

    wr(32'h4002_0008, 3'd2, 32'hDDCC_BBAA, 1'b1, 14'h9, 8'h77);
    wr(32'h4002_000C, 3'd1, 32'h0000_1234, 1'b1, 14'hE, 8'h99);
    rd(32'h4002_0008, 3'd2);
    chk("model_w8", last_rd, 32'hDDCC_BBAA);
    rd(32'h4002_000C, 3'd2);
    chk("model_wC", last_rd, 32'h3F99_1234);
    idle();

    addr_phase(32'h4002_0010, 1'b1, 3'd0);
    step(1'b0, 1'b0, 1'b1);
    drive_idle();
    ahb.hwdata = 32'h0000_0055;
    reset = 1'b0;
    load_en = 1'b1; load_addr = 14'h11; load_data = 8'hEE;
    last_rd = '0;
    step(1'b1, 1'b0, 1'b0);
    load_en = 1'b0;
    reset = 1'b1;
    idle();
    rd(32'h4002_0010, 3'd1);
    chk("model_hw10", last_rd, 32'h0000_4140);
    idle();
    idle();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
